turn_controller: RTL
====================

# turn_controller

Game-sequencing FSM for the chicken-race board game; it is the initiator side of the turn-evaluation data path. It accepts card flips from the current player, issues same-card check requests, commands chicken moves on a match, samples the win result and, on a miss or timeout, emits the one-cycle next-turn strobe and rotates the current player `T` among `N+1` players.

## Interface

Parameters:
- `TIMEOUT`, default 1000: cycles allowed in WAIT_FLIP before a forced turn pass. The value 0 disables the timeout. Maximum is 65535 (16-bit counter).

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begins a new game; honored in IDLE and DONE.
- `N` in 2: number of players minus 1. Latched on an accepted `start` and ignored otherwise.
- `flip_valid` in 1: one-cycle pulse; the current player flipped a card.
- `flip_idx` in 4: index of the flipped card, valid with `flip_valid`.
- `same_valid` in 1: the checker's response is valid.
- `same_result` in 1: 1 = flipped card matches the target tile.
- `win_valid` in 1: the win checker's response is valid.
- `win_flag` in 1: 1 = the current player has won.
- `check_req` out 1: one-cycle request to the same-card checker.
- `check_idx` out 4: card index under check; held from `check_req` until the next flip.
- `move_req` out 1: one-cycle command to advance the current player's chicken.
- `next_turn` out 1: one-cycle turn-pass strobe (statecombo_next_turn).
- `T` out 2: current player.
- `streak` out 4: matches in the current turn; saturates at 15.
- `dup_flip` out 1: one-cycle pulse when a flip is rejected as a duplicate.
- `winner_valid` out 1: the game is over.
- `winner` out 2: winning player, valid while `winner_valid` is high.

## Operation

- States: IDLE, WAIT_FLIP, CHECK, MOVE, WIN_CHK, NEXT, DONE.
- Internal state: a 16-bit `flipped` mask (cards used this turn), a 16-bit timeout counter, and the latched `n_reg`.
- **IDLE**
  - `start` latches `n_reg=N`, sets `T=0`, clears the mask, streak and counter, then goes to WAIT_FLIP.
- **WAIT_FLIP**
  - The counter increments every cycle.
  - `flip_valid` with `flipped[flip_idx]==0`: set the mask bit, load `check_idx`, go to CHECK.
  - `flip_valid` with `flipped[flip_idx]==1`: pulse `dup_flip` and stay. The counter is not reset.
  - Counter reaching `TIMEOUT-1` (`TIMEOUT`≠0): go to NEXT.
  - If a valid flip and the timeout occur in the same cycle, the flip wins.
- **CHECK**
  - `check_req` is high only in the first CHECK cycle.
  - `same_valid` is honored only from the following cycle onward, with no timeout.
  - `same_result=1`: streak increments (saturating at 15), go to MOVE.
  - `same_result=0`: go to NEXT.
  - `flip_valid` is ignored in this state.
- **MOVE**
  - One cycle with `move_req=1`, then go to WIN_CHK.
- **WIN_CHK**
  - Waits for `win_valid`.
  - `win_flag=1`: `winner=T`, `winner_valid=1`, go to DONE.
  - Otherwise, if the mask is all ones, go to NEXT.
  - Otherwise, clear the counter and go to WAIT_FLIP; the same player continues.
- **NEXT**
  - One cycle with `next_turn=1`.
  - `T` becomes 0 if `T==n_reg`, else `T+1`.
  - Clear the mask, streak and counter, then go to WAIT_FLIP.
- **DONE**
  - Outputs hold and flips are ignored.
  - `start` clears `winner_valid`/`winner`, relatches `N`, sets `T=0`, and clears the mask, streak and counter, then goes to WAIT_FLIP.
- With `N=0` there is a single player; NEXT keeps `T=0` but still strobes `next_turn`.

## Timing

- All outputs are registered.
- Reset values: state IDLE; `T=0`, `check_idx=0`, `streak=0`, `winner=0`; all strobes 0; `winner_valid=0`; mask and counter 0.
- `rst` asserted mid-operation returns the block to IDLE at once. Any pending request is dropped, and late responses are ignored because the block is in IDLE.
- Latency:
  - `flip_valid` sampled at edge k: `check_req` high in cycle k+1.
  - `same_valid`/`same_result=1` sampled at edge j: `move_req` in cycle j+1.
  - Miss sampled at edge j: `next_turn` in cycle j+1, with the new `T` visible from cycle j+2.
- `next_turn`, `move_req`, `check_req` and `dup_flip` are never high for more than one consecutive cycle.

## Test plan

- **Basic match:** `N=1`, `start`, flip idx 5, respond `same=1`, `win=0`. Expect `check_req` with `check_idx=5`, `move_req` one cycle later, `streak=1`, `T=0`, back in WAIT_FLIP.
- **Miss and rotation:** `N=2`, three consecutive misses. Expect three `next_turn` pulses and `T` sequence 0→1→2→0, with `streak` reset each turn.
- **Duplicate flip:** match on idx 3, then flip idx 3 again. Expect a `dup_flip` pulse, no `check_req`, still in WAIT_FLIP; after the turn passes, idx 3 is accepted again.
- **Timeout:** `TIMEOUT=8`, no flips. Expect `next_turn` 8 cycles after entering WAIT_FLIP. With a flip on the 8th cycle, expect `check_req` and no `next_turn`.
- **Win and restart:** match then `win_flag=1` with `T=1`. Expect `winner_valid=1`, `winner=1`, and flips ignored; `start` with `N=3` clears `winner_valid` and sets `T=0`.
- **Reset mid-CHECK:** assert `rst` after `check_req`, then drive `same_valid=1`. Expect all outputs at reset values and no `move_req` or `next_turn`.

Source files
------------

// File: rtl/turn_controller_if.sv
// Control and handshake bundle between the turn controller (master) and the
// card/win checkers plus the game front end (slave).
interface turn_controller_if;
  logic       start;
  logic [1:0] N;
  logic       flip_valid;
  logic [3:0] flip_idx;
  logic       same_valid;
  logic       same_result;
  logic       win_valid;
  logic       win_flag;
  logic       check_req;
  logic [3:0] check_idx;
  logic       move_req;
  logic       next_turn;
  logic [1:0] T;
  logic [3:0] streak;
  logic       dup_flip;
  logic       winner_valid;
  logic [1:0] winner;

  modport master (
    input  start, N, flip_valid, flip_idx, same_valid, same_result,
           win_valid, win_flag,
    output check_req, check_idx, move_req, next_turn, T, streak,
           dup_flip, winner_valid, winner
  );

  modport slave (
    output start, N, flip_valid, flip_idx, same_valid, same_result,
           win_valid, win_flag,
    input  check_req, check_idx, move_req, next_turn, T, streak,
           dup_flip, winner_valid, winner
  );
endinterface

// File: rtl/turn_controller.sv
// Chicken-race turn sequencer: accepts flips, requests same-card checks,
// commands moves on matches, detects the winner and rotates the current player.
module turn_controller #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  turn_controller_if.master bus
);
  localparam int unsigned CW       = 16;
  localparam int unsigned NW       = 2;
  localparam int unsigned IW       = 4;
  localparam int unsigned SW       = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam bit          TO_EN    = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FLIP, S_CHECK, S_MOVE, S_WIN_CHK, S_NEXT, S_DONE
  } state_e;

  state_e          state_q;
  logic [NW-1:0]   n_q;
  logic [NW-1:0]   t_q;
  logic [15:0]     mask_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   check_idx_q;
  logic [SW-1:0]   streak_q;
  logic [NW-1:0]   winner_q;
  logic            winner_valid_q;
  logic            check_req_q;
  logic            move_req_q;
  logic            next_turn_q;
  logic            dup_flip_q;

  // Strobes are raised on the transition into the state that owns them,
  // so each one is high exactly during the first cycle of that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      t_q            <= '0;
      mask_q         <= '0;
      cnt_q          <= '0;
      check_idx_q    <= '0;
      streak_q       <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      check_req_q    <= 1'b0;
      move_req_q     <= 1'b0;
      next_turn_q    <= 1'b0;
      dup_flip_q     <= 1'b0;
    end else begin
      check_req_q <= 1'b0;
      move_req_q  <= 1'b0;
      next_turn_q <= 1'b0;
      dup_flip_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            n_q            <= bus.N;
            t_q            <= '0;
            mask_q         <= '0;
            streak_q       <= '0;
            cnt_q          <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            state_q        <= S_WAIT_FLIP;
          end
        end
        S_WAIT_FLIP: begin
          cnt_q <= cnt_q + CW'(1);
          if (bus.flip_valid && !mask_q[bus.flip_idx]) begin
            mask_q[bus.flip_idx] <= 1'b1;
            check_idx_q          <= bus.flip_idx;
            check_req_q          <= 1'b1;
            state_q              <= S_CHECK;
          end else begin
            if (bus.flip_valid) begin
              dup_flip_q <= 1'b1;
            end
            if (TO_EN && (cnt_q == CNT_LAST)) begin
              next_turn_q <= 1'b1;
              state_q     <= S_NEXT;
            end
          end
        end
        S_CHECK: begin
          // A response in the request cycle itself is not trusted.
          if (!check_req_q && bus.same_valid) begin
            if (bus.same_result) begin
              streak_q   <= (&streak_q) ? streak_q : streak_q + SW'(1);
              move_req_q <= 1'b1;
              state_q    <= S_MOVE;
            end else begin
              next_turn_q <= 1'b1;
              state_q     <= S_NEXT;
            end
          end
        end
        S_MOVE: begin
          state_q <= S_WIN_CHK;
        end
        S_WIN_CHK: begin
          if (bus.win_valid) begin
            if (bus.win_flag) begin
              winner_q       <= t_q;
              winner_valid_q <= 1'b1;
              state_q        <= S_DONE;
            end else if (&mask_q) begin
              next_turn_q <= 1'b1;
              state_q     <= S_NEXT;
            end else begin
              cnt_q   <= '0;
              state_q <= S_WAIT_FLIP;
            end
          end
        end
        S_NEXT: begin
          t_q      <= (t_q == n_q) ? NW'(0) : t_q + NW'(1);
          mask_q   <= '0;
          streak_q <= '0;
          cnt_q    <= '0;
          state_q  <= S_WAIT_FLIP;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.check_req    = check_req_q;
  assign bus.check_idx    = check_idx_q;
  assign bus.move_req     = move_req_q;
  assign bus.next_turn    = next_turn_q;
  assign bus.T            = t_q;
  assign bus.streak       = streak_q;
  assign bus.dup_flip     = dup_flip_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.winner       = winner_q;
endmodule
